// File: rtl/uart_pkg.sv
// Shared definitions for the UART command-frame controller: command bytes,
// error codes, FSM encoding and the frame checksum helper.
package uart_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam logic [7:0] CMD_WR      = 8'h01;
    localparam logic [7:0] CMD_RD      = 8'h02;

    localparam logic [1:0] ERR_CHECKSUM = 2'b00;
    localparam logic [1:0] ERR_BAD_CMD  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_OVERRUN  = 2'b11;

    localparam int TIMER_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_CMD  = 3'd1,
        ST_GET_ADDR = 3'd2,
        ST_GET_DATA = 3'd3,
        ST_GET_CHK  = 3'd4,
        ST_ISSUE    = 3'd5
    } state_e;

    // 8-bit wrap-around sum of the three payload bytes.
    function automatic logic [7:0] frame_sum(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [7:0] c);
        return a + b + c;
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle counter: cleared by clr or when disabled, saturates at LIMIT-1
// and flags hit while parked there (never in a cycle where clr is asserted).
module uart_byte_timer #(
    parameter int LIMIT = 208320,
    parameter int WIDTH = 24
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr || !en) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = en && !clr && (count_q == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses [SOF][CMD][ADDR][DATA][CHK] frames from the UART receiver and issues
// one register request per good frame over a valid/ready handshake.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int          CLK_FREQ      = 50000000,
    parameter int          UART_BPS      = 9600,
    parameter logic [7:0]  SOF           = SOF_DEFAULT,
    parameter int          TIMEOUT_BYTES = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_done,
    input  logic [7:0] uart_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_wr,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_wdata,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int TO_CNT = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;

    state_e     state_q, state_d;
    logic       uart_done_q;
    logic [7:0] cmd_byte_q, cmd_byte_d;
    logic [7:0] addr_byte_q, addr_byte_d;
    logic [7:0] data_byte_q, data_byte_d;
    logic       cmd_wr_q, cmd_wr_d;
    logic [7:0] cmd_addr_q, cmd_addr_d;
    logic [7:0] cmd_wdata_q, cmd_wdata_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0] err_code_q, err_code_d;

    logic byte_evt;
    logic timer_en;
    logic timeout;
    logic chk_ok;
    logic cmd_ok;

    // The receiver may hold uart_done for many cycles; only its rising edge counts.
    assign byte_evt = uart_done && !uart_done_q;
    assign timer_en = (state_q == ST_GET_CMD) || (state_q == ST_GET_ADDR) ||
                      (state_q == ST_GET_DATA) || (state_q == ST_GET_CHK);
    assign chk_ok   = (uart_data == frame_sum(cmd_byte_q, addr_byte_q, data_byte_q));
    assign cmd_ok   = (cmd_byte_q == CMD_WR) || (cmd_byte_q == CMD_RD);

    uart_byte_timer #(
        .LIMIT (TO_CNT),
        .WIDTH (TIMER_W)
    ) u_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (byte_evt),
        .en        (timer_en),
        .hit       (timeout)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (byte_evt && (uart_data == SOF)) state_d = ST_GET_CMD;
            end
            ST_GET_CMD: begin
                if (byte_evt)     state_d = ST_GET_ADDR;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_GET_ADDR: begin
                if (byte_evt)     state_d = ST_GET_DATA;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_GET_DATA: begin
                if (byte_evt)     state_d = ST_GET_CHK;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_GET_CHK: begin
                if (byte_evt)     state_d = (chk_ok && cmd_ok) ? ST_ISSUE : ST_IDLE;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (cmd_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_byte_d  = cmd_byte_q;
        addr_byte_d = addr_byte_q;
        data_byte_d = data_byte_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        // The timer never hits on a byte-event cycle, so the byte always wins.
        if (timeout) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end

        if (byte_evt) begin
            case (state_q)
                ST_GET_CMD:  cmd_byte_d  = uart_data;
                ST_GET_ADDR: addr_byte_d = uart_data;
                ST_GET_DATA: data_byte_d = uart_data;
                ST_GET_CHK: begin
                    if (!chk_ok) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHECKSUM;
                    end else if (!cmd_ok) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_BAD_CMD;
                    end else begin
                        cmd_wr_d    = (cmd_byte_q == CMD_WR);
                        cmd_addr_d  = addr_byte_q;
                        cmd_wdata_d = data_byte_q;
                    end
                end
                ST_ISSUE: begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            uart_done_q <= 1'b0;
            cmd_byte_q  <= '0;
            addr_byte_q <= '0;
            data_byte_q <= '0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            uart_done_q <= uart_done;
            cmd_byte_q  <= cmd_byte_d;
            addr_byte_q <= addr_byte_d;
            data_byte_q <= data_byte_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign cmd_valid = (state_q == ST_ISSUE);
    assign cmd_wr    = cmd_wr_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_uart_frame_ctrl;

    localparam int CLK_FREQ      = 100000;
    localparam int UART_BPS      = 10000;
    localparam int TIMEOUT_BYTES = 4;
    localparam int TO_CNT        = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_done = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic       cmd_wr;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       frame_err;
    logic [1:0] err_code;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int evt_cycle = 0;
    logic post_valid = 1'b0;
    logic post_err = 1'b0;

    logic [16:0] acc_q[$];
    logic [1:0]  err_q[$];
    int valid_cycles = 0;
    int unstable = 0;
    int dropped = 0;
    int long_err = 0;
    logic prev_hold = 1'b0;
    logic prev_err = 1'b0;
    logic [16:0] prev_fields = '0;

    uart_frame_ctrl #(
        .CLK_FREQ      (CLK_FREQ),
        .UART_BPS      (UART_BPS),
        .SOF           (8'hA5),
        .TIMEOUT_BYTES (TIMEOUT_BYTES)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .uart_done (uart_done),
        .uart_data (uart_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive observer: records accepted requests and error pulses, and watches
    // the handshake hold rules and the single-cycle error pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (frame_err && prev_err) long_err++;
            prev_err = frame_err;
            if (frame_err) err_q.push_back(err_code);
            if (prev_hold) begin
                if (!cmd_valid) dropped++;
                else if ({cmd_wr, cmd_addr, cmd_wdata} != prev_fields) unstable++;
            end
            prev_hold   = cmd_valid && !cmd_ready;
            prev_fields = {cmd_wr, cmd_addr, cmd_wdata};
            if (cmd_valid && cmd_ready) acc_q.push_back({cmd_wr, cmd_addr, cmd_wdata});
            if (cmd_valid) valid_cycles++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        acc_q.delete();
        err_q.delete();
        valid_cycles = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int hold = $urandom_range(1, 6);
        int gap  = $urandom_range(3, 30);
        uart_data = b;
        uart_done = 1'b1;
        tick();
        evt_cycle  = cyc;
        post_valid = cmd_valid;
        post_err   = frame_err;
        repeat (hold - 1) tick();
        uart_done = 1'b0;
        uart_data = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 0; i < 5; i++) send_byte(f[39 - 8*i -: 8]);
        $display("frame %010h sent", f);
    endtask

    // Frame-level reference: checksum first, then command legality.
    function automatic void ref_frame(input logic [39:0] f, output bit ok,
                                      output logic [1:0] code, output logic [16:0] fields);
        int c = int'(f[31:24]);
        int a = int'(f[23:16]);
        int d = int'(f[15:8]);
        int k = int'(f[7:0]);
        ok = 1'b0;
        code = 2'b00;
        fields = '0;
        if ((c + a + d) % 256 != k) code = 2'b00;
        else if (c != 1 && c != 2) code = 2'b01;
        else begin
            ok = 1'b1;
            fields = {(c == 1), f[23:16], f[15:8]};
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({cmd_valid, cmd_wr, cmd_addr, cmd_wdata, frame_err, err_code} !== 21'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %0h required 0",
                     {cmd_valid, cmd_wr, cmd_addr, cmd_wdata, frame_err, err_code});
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_write();
        clear_mon();
        cmd_ready = 1'b1;
        send_frame(40'hA5_01_10_3C_4D);
        n_cmp++;
        if (post_valid !== 1'b1) begin
            n_bad++; $display("FAIL write_latency: cmd_valid=%0b one cycle after CHK, required 1", post_valid);
        end
        repeat (5) tick();
        n_cmp++;
        if (acc_q.size() != 1 || acc_q[0] !== {1'b1, 8'h10, 8'h3C}) begin
            n_bad++; $display("FAIL write_accept: got %0d reqs first %05h, required 1 req 1103c", acc_q.size(), acc_q[0]);
        end
        n_cmp++;
        if (valid_cycles != 1 || err_q.size() != 0) begin
            n_bad++; $display("FAIL write_pulse: valid_cycles=%0d errs=%0d, required 1 and 0", valid_cycles, err_q.size());
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_read_stall();
        int held = 0;
        clear_mon();
        cmd_ready = 1'b0;
        send_frame(40'hA5_02_20_00_22);
        repeat (50) begin
            tick();
            if (cmd_valid) held++;
        end
        n_cmp++;
        if (held != 50) begin
            n_bad++; $display("FAIL read_hold: cmd_valid high %0d of 50 stalled cycles, required 50", held);
        end
        cmd_ready = 1'b1;
        tick();
        n_cmp++;
        if (cmd_valid !== 1'b0) begin
            n_bad++; $display("FAIL read_drop: cmd_valid=%0b one cycle after ready, required 0", cmd_valid);
        end
        cmd_ready = 1'b0;
        n_cmp++;
        if (acc_q.size() != 1 || acc_q[0] !== {1'b0, 8'h20, 8'h00}) begin
            n_bad++; $display("FAIL read_accept: got %0d reqs first %05h, required 1 req 02000", acc_q.size(), acc_q[0]);
        end
        n_cmp++;
        if (unstable != 0 || dropped != 0) begin
            n_bad++; $display("FAIL read_stable: unstable=%0d dropped=%0d, required 0 and 0", unstable, dropped);
        end
    endtask

    task automatic test_errors();
        clear_mon();
        cmd_ready = 1'b1;
        send_frame(40'hA5_01_10_3C_4E);
        n_cmp++;
        if (post_err !== 1'b1 || err_code !== 2'b00) begin
            n_bad++; $display("FAIL chk_err: frame_err=%0b code=%0b, required 1 and 00", post_err, err_code);
        end
        send_frame(40'hA5_07_00_00_07);
        repeat (3) tick();
        n_cmp++;
        if (err_q.size() != 2 || err_q[1] !== 2'b01 || err_code !== 2'b01) begin
            n_bad++; $display("FAIL badcmd_err: %0d errs last=%0b held=%0b, required 2 errs 01 01", err_q.size(), err_q[1], err_code);
        end
        n_cmp++;
        if (acc_q.size() != 0 || valid_cycles != 0) begin
            n_bad++; $display("FAIL err_no_cmd: reqs=%0d valid_cycles=%0d, required 0", acc_q.size(), valid_cycles);
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_noise_wrap();
        clear_mon();
        cmd_ready = 1'b1;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        send_frame(40'hA5_01_10_3C_4D);
        send_frame(40'hA5_01_FF_FF_FF);
        repeat (3) tick();
        n_cmp++;
        if (acc_q.size() != 2 || acc_q[0] !== {1'b1, 8'h10, 8'h3C} || acc_q[1] !== {1'b1, 8'hFF, 8'hFF}) begin
            n_bad++; $display("FAIL noise_wrap: %0d reqs %05h %05h, required 2: 1103c 1ffff", acc_q.size(), acc_q[0], acc_q[1]);
        end
        n_cmp++;
        if (err_q.size() != 0) begin
            n_bad++; $display("FAIL noise_silent: %0d errors, required 0", err_q.size());
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int lat;
        clear_mon();
        cmd_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h01);
        while (!frame_err && (cyc - evt_cycle) < TO_CNT + 20) tick();
        lat = cyc - evt_cycle;
        n_cmp++;
        if (frame_err !== 1'b1 || err_code !== 2'b10) begin
            n_bad++; $display("FAIL timeout_err: frame_err=%0b code=%0b after %0d cycles, required 1 and 10", frame_err, err_code, lat);
        end
        n_cmp++;
        if (lat != TO_CNT) begin
            n_bad++; $display("FAIL timeout_latency: error %0d cycles after last byte, required %0d", lat, TO_CNT);
        end
        tick();
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_bad++; $display("FAIL timeout_pulse: frame_err=%0b second cycle, required 0", frame_err);
        end
        send_frame(40'hA5_01_10_3C_4D);
        repeat (3) tick();
        n_cmp++;
        if (acc_q.size() != 1 || acc_q[0] !== {1'b1, 8'h10, 8'h3C}) begin
            n_bad++; $display("FAIL timeout_recover: %0d reqs first %05h, required 1 req 1103c", acc_q.size(), acc_q[0]);
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_overrun();
        clear_mon();
        cmd_ready = 1'b0;
        send_frame(40'hA5_01_10_3C_4D);
        send_byte(8'h77);
        n_cmp++;
        if (post_err !== 1'b1 || err_code !== 2'b11) begin
            n_bad++; $display("FAIL overrun_err: frame_err=%0b code=%0b, required 1 and 11", post_err, err_code);
        end
        n_cmp++;
        if (cmd_valid !== 1'b1 || {cmd_wr, cmd_addr, cmd_wdata} !== {1'b1, 8'h10, 8'h3C}) begin
            n_bad++; $display("FAIL overrun_hold: valid=%0b fields=%05h, required 1 and 1103c", cmd_valid, {cmd_wr, cmd_addr, cmd_wdata});
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        n_cmp++;
        if (acc_q.size() != 1 || acc_q[0] !== {1'b1, 8'h10, 8'h3C} || unstable != 0) begin
            n_bad++; $display("FAIL overrun_accept: %0d reqs first %05h unstable=%0d, required 1 1103c 0", acc_q.size(), acc_q[0], unstable);
        end
    endtask

    task automatic test_reset_mid();
        cmd_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h10);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_valid, cmd_wr, cmd_addr, cmd_wdata, frame_err, err_code} !== 21'h0) begin
            n_bad++; $display("FAIL reset_midframe: outputs %0h, required 0", {cmd_valid, cmd_wr, cmd_addr, cmd_wdata, frame_err, err_code});
        end
        tick();
        rst_n = 1'b1;
        cmd_ready = 1'b0;
        send_frame(40'hA5_01_10_3C_4D);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_valid, cmd_wr, cmd_addr, cmd_wdata} !== 18'h0) begin
            n_bad++; $display("FAIL reset_issue: valid/fields %0h, required 0", {cmd_valid, cmd_wr, cmd_addr, cmd_wdata});
        end
        tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        cmd_ready = 1'b1;
        send_frame(40'hA5_02_20_00_22);
        repeat (3) tick();
        n_cmp++;
        if (acc_q.size() != 1 || acc_q[0] !== {1'b0, 8'h20, 8'h00}) begin
            n_bad++; $display("FAIL reset_recover: %0d reqs first %05h, required 1 req 02000", acc_q.size(), acc_q[0]);
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic [7:0]  c, a, d, k, n;
            logic [39:0] f;
            bit          ok;
            logic [1:0]  code;
            logic [16:0] fields;
            int          waited = 0;
            c = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(1, 2)) : 8'($urandom);
            a = 8'($urandom);
            d = 8'($urandom);
            k = 8'((int'(c) + int'(a) + int'(d)) % 256);
            if ($urandom_range(0, 9) < 3) k = k + 8'($urandom_range(1, 255));
            f = {8'hA5, c, a, d, k};
            ref_frame(f, ok, code, fields);
            clear_mon();
            cmd_ready = 1'($urandom_range(0, 1));
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                do n = 8'($urandom); while (n == 8'hA5);
                send_byte(n);
            end
            send_frame(f);
            while (cmd_valid && waited < 200) begin
                cmd_ready = 1'($urandom_range(0, 1));
                tick();
                waited++;
            end
            cmd_ready = 1'b0;
            tick();
            n_cmp++;
            if (cmd_valid !== 1'b0) begin
                n_bad++; $display("FAIL rand_done[%0d]: cmd_valid still %0b after bound, required 0", it, cmd_valid);
            end
            if (ok) begin
                n_cmp++;
                if (acc_q.size() != 1 || acc_q[0] !== fields || err_q.size() != 0) begin
                    n_bad++; $display("FAIL rand_accept[%0d]: %0d reqs %05h errs %0d, required 1 %05h 0", it, acc_q.size(), acc_q[0], err_q.size(), fields);
                end
            end else begin
                n_cmp++;
                if (acc_q.size() != 0 || err_q.size() != 1 || err_q[0] !== code) begin
                    n_bad++; $display("FAIL rand_error[%0d]: %0d reqs %0d errs code %0b, required 0 1 %0b", it, acc_q.size(), err_q.size(), err_q[0], code);
                end
            end
        end
        n_cmp++;
        if (long_err != 0 || unstable != 0 || dropped != 0) begin
            n_bad++; $display("FAIL protocol: long_err=%0d unstable=%0d dropped=%0d, required all 0", long_err, unstable, dropped);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_errors();
        test_noise_wrap();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
